// File: rtl/fwd_hazard_if.sv
// Pipeline-side bundle for the forwarding / load-use hazard unit.
// The slave modport is the unit itself; the master modport is the surrounding pipeline.
interface fwd_hazard_if #(
  parameter int XLEN = 64
);
  logic            flush;
  logic            id_valid;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic [4:0]      id_ex_rd;
  logic            id_ex_memread;
  logic [4:0]      ex_rs1;
  logic [4:0]      ex_rs2;
  logic [XLEN-1:0] ex_rs1_data;
  logic [XLEN-1:0] ex_rs2_data;
  logic [4:0]      ex_mem_rd;
  logic            ex_mem_regwrite;
  logic [XLEN-1:0] ex_mem_result;
  logic [4:0]      mem_wb_rd;
  logic            mem_wb_regwrite;
  logic [XLEN-1:0] mem_wb_data;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [1:0]      fwd_a;
  logic [1:0]      fwd_b;
  logic            stall;
  logic            bubble;
  logic            hist_valid;

  modport master (
    output flush, id_valid, id_rs1, id_rs2, id_ex_rd, id_ex_memread,
           ex_rs1, ex_rs2, ex_rs1_data, ex_rs2_data,
           ex_mem_rd, ex_mem_regwrite, ex_mem_result,
           mem_wb_rd, mem_wb_regwrite, mem_wb_data,
    input  op_a, op_b, fwd_a, fwd_b, stall, bubble, hist_valid
  );

  modport slave (
    input  flush, id_valid, id_rs1, id_rs2, id_ex_rd, id_ex_memread,
           ex_rs1, ex_rs2, ex_rs1_data, ex_rs2_data,
           ex_mem_rd, ex_mem_regwrite, ex_mem_result,
           mem_wb_rd, mem_wb_regwrite, mem_wb_data,
    output op_a, op_b, fwd_a, fwd_b, stall, bubble, hist_valid
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// EX-stage operand forwarding (EX/MEM, MEM/WB, write-back history, regfile)
// plus a LOAD_STALL-cycle load-use stall/bubble generator.
module fwd_hazard_unit #(
  parameter int XLEN       = 64,
  parameter int LOAD_STALL = 1,
  parameter int HIST_EN    = 1
) (
  input logic         clk,
  input logic         rst_n,
  fwd_hazard_if.slave bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] STALL = 1'b1;

  localparam logic [1:0] SEL_RF   = 2'b00;
  localparam logic [1:0] SEL_WB   = 2'b01;
  localparam logic [1:0] SEL_MEM  = 2'b10;
  localparam logic [1:0] SEL_HIST = 2'b11;

  localparam logic [1:0] STALL_INIT = 2'(LOAD_STALL - 1);

  logic [0:0]      state, state_next;
  logic [1:0]      cnt, cnt_next;
  logic            hist_valid;
  logic [4:0]      hist_rd;
  logic [XLEN-1:0] hist_data;
  logic            hz;
  logic [1:0]      sel_a, sel_b;
  logic            stall_c, bubble_c;

  function automatic logic [1:0] pick_src(
    input logic [4:0] rs,
    input logic       mem_rw,
    input logic [4:0] mem_rd,
    input logic       wb_rw,
    input logic [4:0] wb_rd,
    input logic       h_valid,
    input logic [4:0] h_rd
  );
    logic [1:0] sel;
    sel = SEL_RF;
    if (rs == 5'd0)
      sel = SEL_RF;
    else if (mem_rw && (mem_rd == rs))
      sel = SEL_MEM;
    else if (wb_rw && (wb_rd == rs))
      sel = SEL_WB;
    else if ((HIST_EN != 0) && h_valid && (h_rd == rs))
      sel = SEL_HIST;
    return sel;
  endfunction

  function automatic logic [XLEN-1:0] pick_val(
    input logic [1:0]      sel,
    input logic [XLEN-1:0] rf,
    input logic [XLEN-1:0] wb,
    input logic [XLEN-1:0] mem,
    input logic [XLEN-1:0] hist
  );
    logic [XLEN-1:0] v;
    case (sel)
      SEL_MEM:  v = mem;
      SEL_WB:   v = wb;
      SEL_HIST: v = hist;
      default:  v = rf;
    endcase
    return v;
  endfunction

  always_comb begin
    sel_a = pick_src(bus.ex_rs1, bus.ex_mem_regwrite, bus.ex_mem_rd,
                     bus.mem_wb_regwrite, bus.mem_wb_rd, hist_valid, hist_rd);
    sel_b = pick_src(bus.ex_rs2, bus.ex_mem_regwrite, bus.ex_mem_rd,
                     bus.mem_wb_regwrite, bus.mem_wb_rd, hist_valid, hist_rd);
  end

  assign bus.fwd_a = sel_a;
  assign bus.fwd_b = sel_b;
  assign bus.op_a  = pick_val(sel_a, bus.ex_rs1_data, bus.mem_wb_data,
                              bus.ex_mem_result, hist_data);
  assign bus.op_b  = pick_val(sel_b, bus.ex_rs2_data, bus.mem_wb_data,
                              bus.ex_mem_result, hist_data);

  // One-deep copy of last cycle's write-back, for regfiles without write-through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_valid <= 1'b0;
      hist_rd    <= 5'd0;
      hist_data  <= '0;
    end else begin
      hist_valid <= bus.mem_wb_regwrite && (bus.mem_wb_rd != 5'd0);
      hist_rd    <= bus.mem_wb_rd;
      hist_data  <= bus.mem_wb_data;
    end
  end

  assign bus.hist_valid = hist_valid;

  assign hz = bus.id_valid && bus.id_ex_memread && (bus.id_ex_rd != 5'd0) &&
              ((bus.id_ex_rd == bus.id_rs1) || (bus.id_ex_rd == bus.id_rs2));

  // The first stall cycle comes straight from hz; STALL covers the remaining ones.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    stall_c    = 1'b0;
    bubble_c   = 1'b0;
    case (state)
      IDLE: begin
        if (hz && !bus.flush) begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
          if (LOAD_STALL > 1) begin
            state_next = STALL;
            cnt_next   = STALL_INIT;
          end
        end
      end
      STALL: begin
        if (bus.flush) begin
          state_next = IDLE;
          cnt_next   = 2'd0;
        end else begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
          if (cnt <= 2'd1) begin
            state_next = IDLE;
            cnt_next   = 2'd0;
          end else begin
            cnt_next = cnt - 2'd1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  assign bus.stall  = stall_c;
  assign bus.bubble = bubble_c;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench: three units (LOAD_STALL 1/2/3, history off on the first)
// share one stimulus; forwarding from a vector table, stalls from hand sequences.
`timescale 1ns/1ps
module tb_fwd_hazard_unit;

  localparam logic [63:0] RF1 = 64'h1111;
  localparam logic [63:0] RF2 = 64'h2222;

  typedef struct {
    logic        flush;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_ex_rd;
    logic        id_ex_memread;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic [63:0] ex_rs1_data;
    logic [63:0] ex_rs2_data;
    logic [4:0]  ex_mem_rd;
    logic        ex_mem_regwrite;
    logic [63:0] ex_mem_result;
    logic [4:0]  mem_wb_rd;
    logic        mem_wb_regwrite;
    logic [63:0] mem_wb_data;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic [1:0]  fwd_a;
    logic [63:0] op_a;
    logic [1:0]  fwd_b;
    logic [63:0] op_b;
    logic        hist_valid;
  } vec_t;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  stim_t cur;
  int    total = 0;
  int    bad = 0;
  vec_t  vecs[9];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    fwd_hazard_if #(.XLEN(64)) bus ();
    assign bus.flush           = cur.flush;
    assign bus.id_valid        = cur.id_valid;
    assign bus.id_rs1          = cur.id_rs1;
    assign bus.id_rs2          = cur.id_rs2;
    assign bus.id_ex_rd        = cur.id_ex_rd;
    assign bus.id_ex_memread   = cur.id_ex_memread;
    assign bus.ex_rs1          = cur.ex_rs1;
    assign bus.ex_rs2          = cur.ex_rs2;
    assign bus.ex_rs1_data     = cur.ex_rs1_data;
    assign bus.ex_rs2_data     = cur.ex_rs2_data;
    assign bus.ex_mem_rd       = cur.ex_mem_rd;
    assign bus.ex_mem_regwrite = cur.ex_mem_regwrite;
    assign bus.ex_mem_result   = cur.ex_mem_result;
    assign bus.mem_wb_rd       = cur.mem_wb_rd;
    assign bus.mem_wb_regwrite = cur.mem_wb_regwrite;
    assign bus.mem_wb_data     = cur.mem_wb_data;

    fwd_hazard_unit #(
      .XLEN(64),
      .LOAD_STALL(g + 1),
      .HIST_EN((g == 0) ? 0 : 1)
    ) u_dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
    );
  end

  function automatic stim_t idle_stim();
    stim_t s;
    s = '{default: '0};
    s.ex_rs1_data = RF1;
    s.ex_rs2_data = RF2;
    return s;
  endfunction

  function automatic stim_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] mrd, input logic mrw, input logic [63:0] mres,
                               input logic [4:0] wrd, input logic wrw, input logic [63:0] wdat);
    stim_t s;
    s = idle_stim();
    s.ex_rs1 = rs1;          s.ex_rs2 = rs2;
    s.ex_mem_rd = mrd;       s.ex_mem_regwrite = mrw;  s.ex_mem_result = mres;
    s.mem_wb_rd = wrd;       s.mem_wb_regwrite = wrw;  s.mem_wb_data = wdat;
    return s;
  endfunction

  task automatic setExp(input int i, input logic [1:0] fa, input logic [63:0] oa,
                        input logic [1:0] fb, input logic [63:0] ob, input logic hv);
    vecs[i].fwd_a = fa; vecs[i].op_a = oa;
    vecs[i].fwd_b = fb; vecs[i].op_b = ob;
    vecs[i].hist_valid = hv;
  endtask

  task automatic applyStimulus(input stim_t s);
    cur = s;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkStall(input string name, input logic s1, input logic s2, input logic s3);
    checkOutput({name, " stall ls1"},  64'(g_dut[0].bus.stall),  64'(s1));
    checkOutput({name, " stall ls2"},  64'(g_dut[1].bus.stall),  64'(s2));
    checkOutput({name, " stall ls3"},  64'(g_dut[2].bus.stall),  64'(s3));
    checkOutput({name, " bubble ls1"}, 64'(g_dut[0].bus.bubble), 64'(s1));
    checkOutput({name, " bubble ls2"}, 64'(g_dut[1].bus.bubble), 64'(s2));
    checkOutput({name, " bubble ls3"}, 64'(g_dut[2].bus.bubble), 64'(s3));
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    stim_t s;
    logic [1:0]  e1_fa, e1_fb;
    logic [63:0] e1_oa, e1_ob;

    // Rows are consecutive cycles: history expectations follow the previous row's MEM/WB.
    vecs[0].s = mk(5, 6, 5, 1, 64'hAA, 5, 1, 64'hBB);
    setExp(0, 2'b10, 64'hAA, 2'b00, RF2, 1'b0);
    vecs[1].s = mk(5, 7, 0, 0, 64'h0, 7, 1, 64'h1234);
    setExp(1, 2'b11, 64'hBB, 2'b01, 64'h1234, 1'b1);
    vecs[2].s = mk(3, 7, 0, 0, 64'h0, 0, 0, 64'h0);
    setExp(2, 2'b00, RF1, 2'b11, 64'h1234, 1'b1);
    vecs[3].s = mk(0, 7, 0, 1, 64'hDEAD, 0, 0, 64'h0);
    setExp(3, 2'b00, RF1, 2'b00, RF2, 1'b0);
    vecs[4].s = mk(9, 9, 9, 0, 64'h55, 9, 1, 64'h66);
    setExp(4, 2'b01, 64'h66, 2'b01, 64'h66, 1'b0);
    vecs[5].s = mk(9, 4, 9, 1, 64'hFEDC_BA98_7654_3210, 4, 1, 64'h8000_0000_0000_0001);
    setExp(5, 2'b10, 64'hFEDC_BA98_7654_3210, 2'b01, 64'h8000_0000_0000_0001, 1'b1);
    vecs[6].s = mk(4, 9, 0, 0, 64'h0, 0, 0, 64'h0);
    setExp(6, 2'b11, 64'h8000_0000_0000_0001, 2'b00, RF2, 1'b1);
    vecs[7].s = mk(0, 4, 0, 0, 64'h0, 0, 1, 64'h77);
    vecs[7].s.id_valid = 1'b1; vecs[7].s.id_ex_memread = 1'b1;
    vecs[7].s.id_ex_rd = 5'd0; vecs[7].s.id_rs1 = 5'd0;
    setExp(7, 2'b00, RF1, 2'b00, RF2, 1'b0);
    vecs[8].s = mk(0, 0, 0, 0, 64'h0, 0, 0, 64'h0);
    vecs[8].s.id_valid = 1'b1; vecs[8].s.id_ex_memread = 1'b1;
    vecs[8].s.id_ex_rd = 5'd3; vecs[8].s.id_rs1 = 5'd4; vecs[8].s.id_rs2 = 5'd5;
    setExp(8, 2'b00, RF1, 2'b00, RF2, 1'b0);

    $display("[TB] reset checks");
    applyStimulus(idle_stim());
    #12;
    checkOutput("reset stall",      64'(g_dut[1].bus.stall),      64'd0);
    checkOutput("reset fwd_a",      64'(g_dut[1].bus.fwd_a),      64'd0);
    checkOutput("reset hist_valid", 64'(g_dut[1].bus.hist_valid), 64'd0);
    checkOutput("reset op_b",       g_dut[1].bus.op_b,            RF2);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] forwarding table");
    for (int i = 0; i < 9; i++) begin
      nextCycle();
      applyStimulus(vecs[i].s);
      @(negedge clk);
      checkOutput($sformatf("row%0d fwd_a", i), 64'(g_dut[1].bus.fwd_a), 64'(vecs[i].fwd_a));
      checkOutput($sformatf("row%0d op_a", i),  g_dut[1].bus.op_a,       vecs[i].op_a);
      checkOutput($sformatf("row%0d fwd_b", i), 64'(g_dut[1].bus.fwd_b), 64'(vecs[i].fwd_b));
      checkOutput($sformatf("row%0d op_b", i),  g_dut[1].bus.op_b,       vecs[i].op_b);
      checkOutput($sformatf("row%0d hist_valid", i),
                  64'(g_dut[1].bus.hist_valid), 64'(vecs[i].hist_valid));
      checkOutput($sformatf("row%0d stall", i), 64'(g_dut[1].bus.stall), 64'd0);
      e1_fa = (vecs[i].fwd_a == 2'b11) ? 2'b00 : vecs[i].fwd_a;
      e1_oa = (vecs[i].fwd_a == 2'b11) ? vecs[i].s.ex_rs1_data : vecs[i].op_a;
      e1_fb = (vecs[i].fwd_b == 2'b11) ? 2'b00 : vecs[i].fwd_b;
      e1_ob = (vecs[i].fwd_b == 2'b11) ? vecs[i].s.ex_rs2_data : vecs[i].op_b;
      checkOutput($sformatf("row%0d nohist fwd_a", i), 64'(g_dut[0].bus.fwd_a), 64'(e1_fa));
      checkOutput($sformatf("row%0d nohist op_a", i),  g_dut[0].bus.op_a,       e1_oa);
      checkOutput($sformatf("row%0d nohist fwd_b", i), 64'(g_dut[0].bus.fwd_b), 64'(e1_fb));
      checkOutput($sformatf("row%0d nohist op_b", i),  g_dut[0].bus.op_b,       e1_ob);
    end

    $display("[TB] load-use stall length");
    nextCycle();
    s = idle_stim();
    s.id_valid = 1'b1; s.id_ex_memread = 1'b1; s.id_ex_rd = 5'd3; s.id_rs2 = 5'd3;
    applyStimulus(s);
    @(negedge clk) checkStall("len c0", 1, 1, 1);
    nextCycle();
    s.id_ex_memread = 1'b0;
    applyStimulus(s);
    @(negedge clk) checkStall("len c1", 0, 1, 1);
    nextCycle();
    @(negedge clk) checkStall("len c2", 0, 0, 1);
    nextCycle();
    @(negedge clk) checkStall("len c3", 0, 0, 0);

    $display("[TB] flush during stall");
    nextCycle();
    s = idle_stim();
    s.id_valid = 1'b1; s.id_ex_memread = 1'b1; s.id_ex_rd = 5'd3; s.id_rs1 = 5'd3;
    applyStimulus(s);
    @(negedge clk) checkStall("fl c0", 1, 1, 1);
    nextCycle();
    s.id_ex_memread = 1'b0; s.flush = 1'b1;
    applyStimulus(s);
    @(negedge clk) checkStall("fl c1", 0, 0, 0);
    nextCycle();
    s.flush = 1'b0;
    applyStimulus(s);
    @(negedge clk) checkStall("fl c2", 0, 0, 0);

    $display("[TB] hazard with simultaneous flush");
    nextCycle();
    s = idle_stim();
    s.id_valid = 1'b1; s.id_ex_memread = 1'b1; s.id_ex_rd = 5'd6; s.id_rs2 = 5'd6;
    s.flush = 1'b1;
    applyStimulus(s);
    @(negedge clk) checkStall("hzfl c0", 0, 0, 0);
    nextCycle();
    applyStimulus(idle_stim());
    @(negedge clk) checkStall("hzfl c1", 0, 0, 0);

    $display("[TB] reset mid-stall");
    nextCycle();
    s = idle_stim();
    s.id_valid = 1'b1; s.id_ex_memread = 1'b1; s.id_ex_rd = 5'd8; s.id_rs1 = 5'd8;
    s.mem_wb_rd = 5'd8; s.mem_wb_regwrite = 1'b1; s.mem_wb_data = 64'h99;
    applyStimulus(s);
    @(negedge clk) checkStall("rst c0", 1, 1, 1);
    nextCycle();
    applyStimulus(idle_stim());
    @(negedge clk);
    checkOutput("rst pre stall ls3", 64'(g_dut[2].bus.stall),      64'd1);
    checkOutput("rst pre hist",      64'(g_dut[2].bus.hist_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst stall ls3",  64'(g_dut[2].bus.stall),      64'd0);
    checkOutput("rst bubble ls3", 64'(g_dut[2].bus.bubble),     64'd0);
    checkOutput("rst stall ls2",  64'(g_dut[1].bus.stall),      64'd0);
    checkOutput("rst hist",       64'(g_dut[2].bus.hist_valid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nextCycle();
    @(negedge clk) checkStall("post rst c0", 0, 0, 0);
    nextCycle();
    @(negedge clk) checkStall("post rst c1", 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
